// File: rtl/bounce_gen_if.sv
// Signal bundle between a bounce generator and the logic that feeds and observes it.
// The master drives the clean level and mode; the slave returns the bounced level.
interface bounce_gen_if;
    logic d_in;
    logic enable;
    logic d_out;
    logic busy;

    modport master (
        output d_in,
        output enable,
        input  d_out,
        input  busy
    );

    modport slave (
        input  d_in,
        input  enable,
        output d_out,
        output busy
    );
endinterface

// File: rtl/bounce_gen.sv
// Switch-bounce generator: turns each clean level change on d_in into a burst of
// pseudo-randomly spaced toggles followed by a settle hold; bypass passes the level clean.
module bounce_gen #(
    parameter int            N_BOUNCE = 4,
    parameter int            GAP_W    = 2,
    parameter int            SETTLE   = 16,
    parameter logic [7:0]    SEED     = 8'hA5
) (
    input  logic       sample_clk,
    input  logic       rst_n,
    bounce_gen_if.slave bus
);

    typedef enum logic [1:0] {STABLE, BOUNCE, SETTLE_ST} state_t;

    localparam logic [GAP_W:0] GAP_ONE      = 1;
    localparam logic [4:0]     TOGGLES_INIT = 5'(2 * N_BOUNCE);
    localparam logic [7:0]     SETTLE_INIT  = 8'(SETTLE);

    state_t         state, state_next;
    logic           d_in_q;
    logic           level, level_next;
    logic           d_out_q, d_out_next;
    logic           busy_q;
    logic [4:0]     toggles_left, toggles_next;
    logic [GAP_W:0] gap_cnt, gap_next;
    logic [7:0]     settle_cnt, settle_next;
    logic [7:0]     lfsr;

    logic           lfsr_fb;
    logic           change;
    logic           gap_hit;
    logic           last_toggle;
    logic [GAP_W:0] gap_load;

    // x^8 + x^6 + x^5 + x^4 + 1, maximal length, so the all-zero state is never entered
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign gap_load    = {1'b0, lfsr[GAP_W-1:0]} + GAP_ONE;
    assign change      = (d_in_q != level);
    assign gap_hit     = (gap_cnt == GAP_ONE);
    assign last_toggle = gap_hit && (toggles_left == 5'd1);

    always_ff @(posedge sample_clk) begin
        // NOTE: every register here uses <= so all state updates see pre-edge values.
        if (!rst_n) begin
            state        <= STABLE;
            d_in_q       <= 1'b0;
            level        <= 1'b0;
            d_out_q      <= 1'b0;
            busy_q       <= 1'b0;
            toggles_left <= '0;
            gap_cnt      <= '0;
            settle_cnt   <= '0;
            lfsr         <= SEED;
        end else begin
            state        <= state_next;
            d_in_q       <= bus.d_in;
            level        <= level_next;
            d_out_q      <= d_out_next;
            busy_q       <= (state_next != STABLE);
            toggles_left <= toggles_next;
            gap_cnt      <= gap_next;
            settle_cnt   <= settle_next;
            lfsr         <= {lfsr[6:0], lfsr_fb};
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            STABLE:    if (change && bus.enable) state_next = BOUNCE;
            BOUNCE:    if (last_toggle) state_next = SETTLE_ST;
            SETTLE_ST: if (settle_cnt == 8'd1) state_next = STABLE;
            default:   state_next = STABLE;
        endcase
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a target unassigned (no latches).
        level_next   = level;
        d_out_next   = d_out_q;
        toggles_next = toggles_left;
        gap_next     = gap_cnt;
        settle_next  = settle_cnt;
        unique case (state)
            STABLE: begin
                if (change) begin
                    level_next = d_in_q;
                    d_out_next = d_in_q;
                    if (bus.enable) begin
                        toggles_next = TOGGLES_INIT;
                        gap_next     = gap_load;
                    end
                end
            end
            BOUNCE: begin
                if (gap_hit) begin
                    d_out_next   = ~d_out_q;
                    toggles_next = toggles_left - 5'd1;
                    gap_next     = gap_load;
                    if (toggles_left == 5'd1) settle_next = SETTLE_INIT;
                end else begin
                    gap_next = gap_cnt - GAP_ONE;
                end
            end
            SETTLE_ST: begin
                // toggle count is even, so this only restates the committed level
                d_out_next  = level;
                settle_next = settle_cnt - 8'd1;
            end
            default: ;
        endcase
    end

    assign bus.d_out = d_out_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen (N_BOUNCE=2, GAP_W=2, SETTLE=8, SEED=A5): exact post-reset
// waveform, burst shape, bypass delay, mid-burst input change, glitch and reset abort.
module tb_bounce_gen;

    logic sample_clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    bounce_gen_if bif ();

    bounce_gen #(
        .N_BOUNCE (2),
        .GAP_W    (2),
        .SETTLE   (8),
        .SEED     (8'hA5)
    ) dut (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .bus        (bif)
    );

    always #5 sample_clk = ~sample_clk;

    // d_out/busy after release edges r1..r21 (bit n-1 = edge rn); LFSR gaps 3,1,2,4 give edges at r2,r5,r6,r8,r12
    localparam logic [20:0] EXP_DOUT_WAVE = 21'b1111111111_0000_11_0_111_0;
    localparam logic [20:0] EXP_BUSY_WAVE = 21'b00_111111111111111111_0;

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_run(input string tag);
        logic [20:0] dw;
        logic [20:0] bw;
        for (int n = 0; n < 21; n++) begin
            tick();
            dw[n] = bif.d_out;
            bw[n] = bif.busy;
        end
        check({tag, "_dout_wave"}, 32'(dw), 32'(EXP_DOUT_WAVE));
        check({tag, "_busy_wave"}, 32'(bw), 32'(EXP_BUSY_WAVE));
    endtask

    // Follow one burst: first edge expected after lat ticks; optionally flip d_in after tick flip_at.
    task automatic watch_burst(input logic exp_final, input int lat, input int flip_at, input string tag);
        logic prev;
        int   edges, first_edge, last_edge, fall, max_gap, min_gap;
        bit   busy_early, busy_at_first;
        prev          = bif.d_out;
        edges         = 0;
        first_edge    = 0;
        last_edge     = 0;
        fall          = 0;
        max_gap       = 0;
        min_gap       = 99;
        busy_early    = 1'b0;
        busy_at_first = 1'b0;
        for (int t = 1; t <= 60 && fall == 0; t++) begin
            tick();
            if (t == flip_at) bif.d_in = ~bif.d_in;
            if (bif.d_out !== prev) begin
                edges++;
                if (first_edge == 0) begin
                    first_edge    = t;
                    busy_at_first = (bif.busy === 1'b1);
                end else begin
                    if (t - last_edge > max_gap) max_gap = t - last_edge;
                    if (t - last_edge < min_gap) min_gap = t - last_edge;
                end
                last_edge = t;
            end else if (first_edge != 0 && bif.busy !== 1'b1) begin
                fall = t;
            end
            if (first_edge == 0 && bif.busy !== 1'b0) busy_early = 1'b1;
            prev = bif.d_out;
        end
        check({tag, "_ended"},       32'(fall != 0),                   32'd1);
        check({tag, "_latency"},     32'(first_edge),                  32'(lat));
        check({tag, "_busy_early"},  32'(busy_early),                  32'd0);
        check({tag, "_busy_rise"},   32'(busy_at_first),               32'd1);
        check({tag, "_edges"},       32'(edges),                       32'd5);
        check({tag, "_gap_range"},   32'(min_gap >= 1 && max_gap <= 4), 32'd1);
        check({tag, "_settle"},      32'(fall - last_edge),            32'd8);
        check({tag, "_busy_len_ok"}, 32'(fall - first_edge <= 24),     32'd1);
        check({tag, "_final"},       32'(bif.d_out),                   32'(exp_final));
    endtask

    initial begin
        logic [6:0] bypass_pat;
        logic [6:0] bypass_exp;
        bypass_pat = 7'b0001011;
        bypass_exp = 7'b0010111;

        // Reset held 3 cycles with d_in=1; burst after release is checked cycle-exact
        rst_n      = 1'b0;
        bif.d_in   = 1'b1;
        bif.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_dout", 32'(bif.d_out), 32'd0);
            check("rst_busy", 32'(bif.busy),  32'd0);
        end
        rst_n = 1'b1;
        check_reset_run("run1");

        // Falling then rising burst from a settled level
        bif.d_in = 1'b0;
        watch_burst(1'b0, 2, 0, "fall");
        bif.d_in = 1'b1;
        watch_burst(1'b1, 2, 0, "rise");

        // Bypass: d_out follows d_in with the same pipeline delay, busy stays low
        bif.enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bif.d_in = bypass_pat[i];
            tick();
            check("bypass_dout", 32'(bif.d_out), 32'(bypass_exp[i]));
            check("bypass_busy", 32'(bif.busy),  32'd0);
        end

        // Input returns low mid-burst: rising burst completes, falling burst follows back-to-back
        bif.enable = 1'b1;
        bif.d_in   = 1'b1;
        watch_burst(1'b1, 2, 4, "mid_rise");
        watch_burst(1'b0, 1, 0, "mid_fall");

        // One-cycle glitch still yields a full rising burst, then a falling one
        bif.d_in = 1'b1;
        watch_burst(1'b1, 2, 1, "glitch_rise");
        watch_burst(1'b0, 1, 0, "glitch_fall");
        tick();
        check("glitch_end_dout", 32'(bif.d_out), 32'd0);
        check("glitch_end_busy", 32'(bif.busy),  32'd0);

        // Reset during BOUNCE aborts at once; the repeated run matches the first exactly
        bif.d_in = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_busy_pre", 32'(bif.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_dout", 32'(bif.d_out), 32'd0);
        check("midrst_busy", 32'(bif.busy),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_run("run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
